// File: rtl/cam_deserializer.sv
// Receive endpoint of the 4-bit camera word link: oversamples PCLK/SYNC/DATA,
// reassembles 10-nibble packets into 32-bit words with sticky framing checks.
`timescale 1ns/1ps
module cam_deserializer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter bit          CHECK_PAD    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cam_pclk,
  input  logic        cam_sync,
  input  logic [3:0]  cam_data,
  input  logic        err_clr_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        sync_o,
  output logic        idle_o,
  output logic        framing_error_o
);

  localparam int unsigned   CW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LOAD = CW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] TMO_ONE  = CW'(1);
  localparam logic [3:0]    N_PAD0   = 4'd8;
  localparam logic [3:0]    N_PAD1   = 4'd9;

  // pclk, sync and data share one chain so they stay cycle-aligned
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;

  logic          pclk_prev_q, pclk_prev_d;
  logic [3:0]    n_q, n_d;
  logic [31:0]   word_q, word_d;
  logic          bad_q, bad_d;
  logic          syncp_q, syncp_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          idle_q, idle_d;
  logic          err_q, err_d;
  logic          emit_q, emit_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          so_q, so_d;

  logic       pclk_s;
  logic       sync_s;
  logic [3:0] data_s;
  logic       rise;
  logic       pad_bad;
  logic       misalign;
  logic       data_nib;
  logic       at_pad0;
  logic       set_err;

  assign pclk_s   = sync_q[SYNC_STAGES-1][5];
  assign sync_s   = sync_q[SYNC_STAGES-1][4];
  assign data_s   = sync_q[SYNC_STAGES-1][3:0];
  assign rise     = pclk_s & ~pclk_prev_q;
  assign pad_bad  = CHECK_PAD & (|data_s);
  assign misalign = sync_s & (n_q != N_PAD0);
  assign data_nib = ~sync_s & (n_q < N_PAD0);
  assign at_pad0  = (n_q == N_PAD0);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0],
                   cam_pclk, cam_sync, cam_data};
    pclk_prev_d = pclk_s;
    n_d         = n_q;
    word_d      = word_q;
    bad_d       = bad_q;
    syncp_d     = syncp_q;
    tmo_d       = tmo_q;
    idle_d      = idle_q;
    emit_d      = 1'b0;
    valid_d     = emit_q;
    data_d      = data_q;
    so_d        = so_q;
    set_err     = 1'b0;
    if (rise) begin
      tmo_d  = TMO_LOAD;
      idle_d = 1'b0;
      unique case (1'b1)
        misalign: begin
          set_err = 1'b1;
          bad_d   = 1'b1;
          n_d     = N_PAD1;
        end
        data_nib: begin
          word_d[{n_q[2:0], 2'b00} +: 4] = data_s;
          n_d = n_q + 4'd1;
        end
        at_pad0: begin
          syncp_d = sync_s;
          set_err = pad_bad;
          n_d     = N_PAD1;
        end
        default: begin
          set_err = pad_bad;
          emit_d  = ~bad_q;
          bad_d   = 1'b0;
          n_d     = 4'd0;
        end
      endcase
    end else begin
      if (tmo_q != '0) tmo_d = tmo_q - TMO_ONE;
      // link went quiet: drop any partial word and reframe from nibble 0
      if (tmo_q == TMO_ONE) begin
        idle_d = 1'b1;
        if (n_q != 4'd0) begin
          set_err = 1'b1;
          n_d     = 4'd0;
          bad_d   = 1'b0;
        end
      end
    end
    if (emit_q) begin
      data_d = word_q;
      so_d   = syncp_q;
    end
    if (set_err)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      pclk_prev_q <= 1'b0;
      n_q         <= 4'd0;
      word_q      <= '0;
      bad_q       <= 1'b0;
      syncp_q     <= 1'b0;
      tmo_q       <= TMO_LOAD;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
      emit_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      so_q        <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      pclk_prev_q <= pclk_prev_d;
      n_q         <= n_d;
      word_q      <= word_d;
      bad_q       <= bad_d;
      syncp_q     <= syncp_d;
      tmo_q       <= tmo_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      emit_q      <= emit_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      so_q        <= so_d;
    end
  end

  assign data_o          = data_q;
  assign valid_o         = valid_q;
  assign sync_o          = so_q;
  assign idle_o          = idle_q;
  assign framing_error_o = err_q;

endmodule

// File: tb/tb_cam_deserializer.sv
// Bench for cam_deserializer: drives 10-nibble packets on the pins and
// compares emitted words/flags against a nibble-level reference model.
`timescale 1ns/1ps
module tb_cam_deserializer;

  localparam int S    = 2;
  localparam int T    = 16;
  localparam int LONG = T + 12;

  logic        clk_i     = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cam_pclk  = 1'b0;
  logic        cam_sync  = 1'b0;
  logic [3:0]  cam_data  = 4'd0;
  logic        err_clr_i = 1'b0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        sync_o;
  logic        idle_o;
  logic        framing_error_o;

  cam_deserializer #(
    .SYNC_STAGES (S),
    .IDLE_TIMEOUT(T),
    .CHECK_PAD   (1'b1)
  ) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .cam_pclk       (cam_pclk),
    .cam_sync       (cam_sync),
    .cam_data       (cam_data),
    .err_clr_i      (err_clr_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .sync_o         (sync_o),
    .idle_o         (idle_o),
    .framing_error_o(framing_error_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int last_rise  = 0;
  int last_valid = 0;
  bit prev_valid = 1'b0;
  bit dbl        = 1'b0;

  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      got_q.push_back({sync_o, data_o});
      last_valid = cyc;
      if (prev_valid) dbl = 1'b1;
    end
    prev_valid = (valid_o === 1'b1);
  end

  // reference model: one call per nibble seen on a PCLK rising edge
  int          m_n     = 0;
  logic [31:0] m_word  = '0;
  bit          m_bad   = 1'b0;
  bit          m_syncp = 1'b0;
  bit          m_err   = 1'b0;

  task automatic model_nibble(input logic [3:0] d, input bit s);
    if (s && m_n != 8) begin
      m_err = 1'b1;
      m_bad = 1'b1;
      m_n   = 9;
    end else if (m_n < 8) begin
      m_word[4*m_n +: 4] = d;
      m_n = m_n + 1;
    end else if (m_n == 8) begin
      m_syncp = s;
      if (d != 4'd0) m_err = 1'b1;
      m_n = 9;
    end else begin
      if (d != 4'd0) m_err = 1'b1;
      if (!m_bad) exp_q.push_back({m_syncp, m_word});
      m_bad = 1'b0;
      m_n   = 0;
    end
  endtask

  task automatic model_timeout();
    if (m_n != 0) begin
      m_err = 1'b1;
      m_n   = 0;
      m_bad = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_word = '0; m_bad = 1'b0;
    m_syncp = 1'b0; m_err = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] d, input bit s,
                             input int half, input bit clr_at);
    cam_pclk = 1'b0;
    cam_data = d;
    cam_sync = s;
    repeat (half) @(negedge clk_i);
    cam_pclk  = 1'b1;
    last_rise = cyc;
    model_nibble(d, s);
    if (clr_at) begin
      fork
        begin
          repeat (S) @(negedge clk_i);
          err_clr_i = 1'b1;
          @(negedge clk_i);
          err_clr_i = 1'b0;
        end
      join_none
    end
    repeat (half) @(negedge clk_i);
  endtask

  task automatic send_packet(input logic [31:0] w, input int sync_at,
                             input logic [3:0] p8, input logic [3:0] p9,
                             input int half, input bit clr9, input int len);
    for (int i = 0; i < len; i++) begin
      send_nibble((i < 8) ? w[4*i +: 4] : ((i == 8) ? p8 : p9),
                  (i == sync_at), half, clr9 && (i == 9));
    end
  endtask

  task automatic idle_wait(input int c);
    cam_pclk = 1'b0;
    cam_data = 4'd0;
    cam_sync = 1'b0;
    repeat (c) @(negedge clk_i);
    if (c > T) model_timeout();
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    m_err = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({data_o, valid_o, sync_o, idle_o, framing_error_o} !== {32'h0, 4'b0010}) begin
      n_fail++;
      $display("FAIL reset_in: got d=%h v=%b s=%b i=%b e=%b need d=0 v=0 s=0 i=1 e=0",
               data_o, valid_o, sync_o, idle_o, framing_error_o);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h need 0", data_o);
    end
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b need 0", valid_o);
    end
    n_cmp++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: got %b need 1", idle_o);
    end
    n_cmp++;
    if (framing_error_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b need 0", framing_error_o);
    end
  endtask

  task automatic test_single();
    int t0;
    got_q.delete(); exp_q.delete();
    send_packet(32'h12345678, -1, 4'd0, 4'd0, 2, 1'b0, 10);
    t0 = last_rise;
    while (cyc < t0 + S + T) @(negedge clk_i);
    n_cmp++;
    if (idle_o !== 1'b0) begin
      n_fail++; $display("FAIL single_idle_early: got %b need 0", idle_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL single_idle_return: got %b need 1", idle_o);
    end
    idle_wait(LONG);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d need 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {1'b0, 32'h12345678}) begin
        n_fail++; $display("FAIL single_word: got %h need 012345678", got_q[0]);
      end
      n_cmp++;
      if (last_valid - t0 !== S + 2) begin
        n_fail++; $display("FAIL single_latency: got %0d need %0d", last_valid - t0, S + 2);
      end
    end
    n_cmp++;
    if (framing_error_o !== 1'b0) begin
      n_fail++; $display("FAIL single_err: got %b need 0", framing_error_o);
    end
    n_cmp++;
    if (data_o !== 32'h12345678) begin
      n_fail++; $display("FAIL single_hold: got %h need 12345678", data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] want [3];
    want[0] = {1'b0, 32'hDEADBEEF};
    want[1] = {1'b0, 32'h00000001};
    want[2] = {1'b1, 32'hFFFFFFFF};
    got_q.delete(); exp_q.delete();
    send_packet(32'hDEADBEEF, -1, 4'd0, 4'd0, 2, 1'b0, 10);
    n_cmp++;
    if (idle_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_busy: got %b need 0", idle_o);
    end
    send_packet(32'h00000001, -1, 4'd0, 4'd0, 2, 1'b0, 10);
    send_packet(32'hFFFFFFFF, 8, 4'd0, 4'd0, 2, 1'b0, 10);
    idle_wait(LONG);
    n_cmp++;
    if (got_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d need 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_q[i] !== want[i]) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h need %h", i, got_q[i], want[i]);
        end
      end
    end
    n_cmp++;
    if (framing_error_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_err: got %b need 0", framing_error_o);
    end
  endtask

  task automatic test_misalign();
    got_q.delete(); exp_q.delete();
    send_packet(32'hAAAAAAAA, 5, 4'd0, 4'd0, 2, 1'b0, 10);
    idle_wait(LONG);
    n_cmp++;
    if (framing_error_o !== 1'b1) begin
      n_fail++; $display("FAIL mis_err: got %b need 1", framing_error_o);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL mis_dropped: got %0d words need 0", got_q.size());
    end
    send_packet(32'h55555555, -1, 4'd0, 4'd0, 2, 1'b0, 10);
    idle_wait(LONG);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL mis_count: got %0d need 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {1'b0, 32'h55555555}) begin
        n_fail++; $display("FAIL mis_word: got %h need 055555555", got_q[0]);
      end
    end
    pulse_clr();
    n_cmp++;
    if (framing_error_o !== 1'b0) begin
      n_fail++; $display("FAIL mis_clr: got %b need 0", framing_error_o);
    end
  endtask

  task automatic test_timeout();
    got_q.delete(); exp_q.delete();
    send_packet(32'h9ABCDEF0, -1, 4'd0, 4'd0, 2, 1'b0, 4);
    idle_wait(LONG);
    n_cmp++;
    if (framing_error_o !== 1'b1) begin
      n_fail++; $display("FAIL tmo_err: got %b need 1", framing_error_o);
    end
    n_cmp++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL tmo_idle: got %b need 1", idle_o);
    end
    send_packet(32'hCAFEF00D, -1, 4'd0, 4'd0, 3, 1'b0, 10);
    idle_wait(LONG);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL tmo_count: got %0d need 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {1'b0, 32'hCAFEF00D}) begin
        n_fail++; $display("FAIL tmo_word: got %h need 0cafef00d", got_q[0]);
      end
    end
    pulse_clr();
  endtask

  task automatic test_pad();
    got_q.delete(); exp_q.delete();
    send_packet(32'h0BADF00D, -1, 4'd0, 4'd3, 2, 1'b0, 10);
    idle_wait(LONG);
    n_cmp++;
    if (framing_error_o !== 1'b1) begin
      n_fail++; $display("FAIL pad_err: got %b need 1", framing_error_o);
    end
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL pad_count: got %0d need 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {1'b0, 32'h0BADF00D}) begin
        n_fail++; $display("FAIL pad_word: got %h need 00badf00d", got_q[0]);
      end
    end
    pulse_clr();
    n_cmp++;
    if (framing_error_o !== 1'b0) begin
      n_fail++; $display("FAIL pad_clr: got %b need 0", framing_error_o);
    end
    send_packet(32'h0BADF00D, -1, 4'd0, 4'd3, 2, 1'b1, 10);
    idle_wait(LONG);
    n_cmp++;
    if (framing_error_o !== 1'b1) begin
      n_fail++; $display("FAIL pad_set_wins: got %b need 1", framing_error_o);
    end
    n_cmp++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL pad_count2: got %0d need 2", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    send_packet(32'hFFFFFFFF, -1, 4'd0, 4'd0, 2, 1'b0, 7);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_o, valid_o, sync_o, idle_o, framing_error_o} !== {32'h0, 4'b0010}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got d=%h v=%b s=%b i=%b e=%b need d=0 v=0 s=0 i=1 e=0",
               data_o, valid_o, sync_o, idle_o, framing_error_o);
    end
    model_reset();
    cam_pclk = 1'b0; cam_data = 4'd0; cam_sync = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_i);
    got_q.delete(); exp_q.delete();
    send_packet(32'h13572468, -1, 4'd0, 4'd0, 2, 1'b0, 10);
    idle_wait(LONG);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d need 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== {1'b0, 32'h13572468}) begin
        n_fail++; $display("FAIL rstmid_word: got %h need 013572468", got_q[0]);
      end
    end
    n_cmp++;
    if (framing_error_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_err: got %b need 0", framing_error_o);
    end
  endtask

  task automatic test_random();
    pulse_clr();
    got_q.delete(); exp_q.delete();
    dbl = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] w;
      logic [3:0]  p8, p9;
      int sa, r, len, half;
      w    = $urandom;
      half = $urandom_range(2, 3);
      r    = $urandom_range(0, 9);
      sa   = -1;
      len  = 10;
      if (r == 0) sa = $urandom_range(0, 7);
      else if (r <= 3) sa = 8;
      else if (r == 4) len = $urandom_range(1, 9);
      p8 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      p9 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      send_packet(w, sa, p8, p9, half, 1'b0, len);
      if (len < 10 || $urandom_range(0, 2) == 0) idle_wait(LONG);
    end
    idle_wait(LONG);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d need %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rnd_word%0d: got %h need %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (framing_error_o !== m_err) begin
      n_fail++; $display("FAIL rnd_err: got %b need %b", framing_error_o, m_err);
    end
    n_cmp++;
    if (dbl !== 1'b0) begin
      n_fail++; $display("FAIL rnd_valid_spacing: got back-to-back valid, need none");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    test_reset();
    test_single();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_pad();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
